// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Provides the FSM state type and the default operand widths.
// No ports; imported by seq_divider_12x6.
package div_pkg;

  localparam int DIVIDEND_W_DEF = 12;
  localparam int DIVISOR_W_DEF  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in a dividend bit, trial subtract, select.
// Latency: purely combinational. Backpressure: none.
// Ports: rem_in (partial remainder), bit_in (next dividend bit), divisor,
//        rem_out (next partial remainder), q_bit (quotient bit produced).
module div_step #(
  parameter int DIVISOR_W = 6
) (
  input  logic [DIVISOR_W:0]   rem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   rem_out,
  output logic                 q_bit
);

  logic [DIVISOR_W:0] shifted;
  logic [DIVISOR_W:0] trial;
  logic               ge;

  assign shifted = {rem_in[DIVISOR_W-1:0], bit_in};
  assign trial   = shifted - {1'b0, divisor};
  // A set MSB in rem_in means the true shifted value exceeds 2^(W+1), so it
  // is certainly >= divisor; the modular subtraction above is still exact.
  assign ge      = rem_in[DIVISOR_W] | (shifted >= {1'b0, divisor});

  assign rem_out = ge ? trial : shifted;
  assign q_bit   = ge;

endmodule

// File: rtl/seq_divider_12x6.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Latency: done pulses DIVIDEND_W cycles after the accepting edge (1 for a
// zero divisor when DIV_ZERO_CHECK_EN is defined). Backpressure: start is
// only accepted in IDLE or DONE; it is ignored while busy.
// Ports: clk, rst (sync, active-high), start, dividend, divisor in;
//        busy, done (1-cycle pulse), quotient, remainder, div_by_zero out.
// Build option: DIV_ZERO_CHECK_EN short-circuits division by zero.
module seq_divider_12x6
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

  state_t                  state;
  logic [CNT_W-1:0]        count;
  // Dividend bits shift out of the MSB while quotient bits shift into the LSB.
  logic [DIVIDEND_W-1:0]   dq;
  logic [DIVISOR_W-1:0]    dsr;
  logic [DIVISOR_W:0]      prem;
  logic [DIVISOR_W:0]      rem_next;
  logic                    q_bit;

  div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .rem_in  (prem),
    .bit_in  (dq[DIVIDEND_W-1]),
    .divisor (dsr),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

`ifdef DIV_ZERO_CHECK_EN
  logic dbz;
  // Set for the single cycle between accepting a zero divisor and DONE.
  logic zero_pend;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      dq        <= '0;
      dsr       <= '0;
      prem      <= '0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_CHECK_EN
      dbz       <= 1'b0;
      zero_pend <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
`ifdef DIV_ZERO_CHECK_EN
          if (zero_pend) begin
            state     <= DONE;
            zero_pend <= 1'b0;
            quotient  <= '1;
            remainder <= '0;
            dbz       <= 1'b1;
          end else
`endif
          if (start) begin
            dq    <= dividend;
            dsr   <= divisor;
            prem  <= '0;
            count <= '0;
`ifdef DIV_ZERO_CHECK_EN
            if (divisor == '0) begin
              state     <= IDLE;
              zero_pend <= 1'b1;
            end else begin
              state <= RUN;
            end
`else
            state <= RUN;
`endif
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          dq    <= {dq[DIVIDEND_W-2:0], q_bit};
          prem  <= rem_next;
          count <= count + 1'b1;
          if (count == LAST_STEP) begin
            // Final step result goes straight to the output registers.
            state     <= DONE;
            quotient  <= {dq[DIVIDEND_W-2:0], q_bit};
            remainder <= rem_next[DIVISOR_W-1:0];
`ifdef DIV_ZERO_CHECK_EN
            dbz       <= 1'b0;
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

`ifdef DIV_ZERO_CHECK_EN
  assign div_by_zero = dbz;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider_12x6.sv
// Self-checking bench for seq_divider_12x6 against an arithmetic reference.
// Ports: none (top-level bench).
module tb_seq_divider_12x6;

`ifdef DIV_ZERO_CHECK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] dividend = '0;
  logic [5:0]  divisor = '0;
  logic        busy;
  logic        done;
  logic [11:0] quotient;
  logic [5:0]  remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider_12x6 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1, "watchdog");
  end

  // Reference: plain arithmetic from the behavioural rules.
  task automatic ref_div(input int a, input int b, output int q, output int r,
                         output int dz, output int lat);
    if (b == 0) begin
      q   = 4095;
      r   = ZCHK ? 0 : (a % 64);
      dz  = ZCHK ? 1 : 0;
      lat = ZCHK ? 1 : 12;
    end else begin
      q   = a / b;
      r   = a % b;
      dz  = 0;
      lat = 12;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request that is taken on the next rising edge.
  task automatic launch(input int a, input int b);
    start    = 1'b1;
    dividend = 12'(a);
    divisor  = 6'(b);
    tick();
    start    = 1'b0;
  endtask

  // Edges elapsed since the accepting edge until done is seen (bounded).
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (quotient !== 12'd0) begin errors++; $display("FAIL reset_q: got %0d want 0", quotient); end
    checks++; if (remainder !== 6'd0) begin errors++; $display("FAIL reset_r: got %0d want 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int q, r, dz, lat, elat, bc;
    ref_div(100, 7, q, r, dz, elat);
    launch(100, 7);
    wait_done(lat, bc);
    checks++; if (lat != elat) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, elat); end
    checks++; if (bc != 12) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 12", bc); end
    checks++; if (quotient !== 12'(q)) begin errors++; $display("FAIL basic_q: got %0d want %0d", quotient, q); end
    checks++; if (remainder !== 6'(r)) begin errors++; $display("FAIL basic_r: got %0d want %0d", remainder, r); end
    checks++; if (div_by_zero !== 1'(dz)) begin errors++; $display("FAIL basic_dbz: got %b want %0d", div_by_zero, dz); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_pulse_end: got done=%b busy=%b want 0 0", done, busy); end
    checks++; if (quotient !== 12'(q)) begin errors++; $display("FAIL basic_hold_q: got %0d want %0d", quotient, q); end
  endtask

  task automatic test_patterns();
    int ta [3] = '{4095, 0, 2048};
    int tb [3] = '{63, 5, 1};
    int q, r, dz, lat, elat, bc;
    for (int i = 0; i < 3; i++) begin
      ref_div(ta[i], tb[i], q, r, dz, elat);
      launch(ta[i], tb[i]);
      wait_done(lat, bc);
      checks++; if (lat != elat) begin errors++; $display("FAIL pat%0d_latency: got %0d want %0d", i, lat, elat); end
      checks++; if (quotient !== 12'(q)) begin errors++; $display("FAIL pat%0d_q: got %0d want %0d", i, quotient, q); end
      checks++; if (remainder !== 6'(r)) begin errors++; $display("FAIL pat%0d_r: got %0d want %0d", i, remainder, r); end
      tick();
    end
  endtask

  task automatic test_div_zero();
    int q, r, dz, lat, elat, bc;
    ref_div(37, 0, q, r, dz, elat);
    launch(37, 0);
    wait_done(lat, bc);
    checks++; if (lat != elat) begin errors++; $display("FAIL dz_latency: got %0d want %0d", lat, elat); end
    checks++; if (bc != (ZCHK ? 0 : 12)) begin errors++; $display("FAIL dz_busy_cycles: got %0d want %0d", bc, ZCHK ? 0 : 12); end
    checks++; if (quotient !== 12'(q)) begin errors++; $display("FAIL dz_q: got %0d want %0d", quotient, q); end
    checks++; if (remainder !== 6'(r)) begin errors++; $display("FAIL dz_r: got %0d want %0d", remainder, r); end
    checks++; if (div_by_zero !== 1'(dz)) begin errors++; $display("FAIL dz_flag: got %b want %0d", div_by_zero, dz); end
    tick();
  endtask

  task automatic test_start_in_run();
    int q, r, dz, elat;
    int pulses = 0;
    int first = -1;
    ref_div(200, 9, q, r, dz, elat);
    launch(200, 9);                  // edge k
    for (int i = 0; i < 4; i++) tick();  // edges k+1..k+4
    start    = 1'b1;
    dividend = 12'd50;
    divisor  = 6'd3;
    tick();                          // edge k+5, must be ignored
    start    = 1'b0;
    for (int e = 5; e <= 25; e++) begin
      if (done === 1'b1) begin
        pulses++;
        if (first < 0) first = e;
      end
      tick();
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL run_start_pulses: got %0d want 1", pulses); end
    checks++; if (first != elat) begin errors++; $display("FAIL run_start_latency: got %0d want %0d", first, elat); end
    checks++; if (quotient !== 12'(q)) begin errors++; $display("FAIL run_start_q: got %0d want %0d", quotient, q); end
    checks++; if (remainder !== 6'(r)) begin errors++; $display("FAIL run_start_r: got %0d want %0d", remainder, r); end
  endtask

  task automatic test_reset_abort();
    int q, r, dz, lat, elat, bc;
    int pulses = 0;
    launch(1000, 10);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();                          // edge k+6
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_ctrl: got busy=%b done=%b want 0 0", busy, done); end
    checks++; if (quotient !== 12'd0 || remainder !== 6'd0 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL abort_outputs: got q=%0d r=%0d dz=%b want 0 0 0", quotient, remainder, div_by_zero);
    end
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) pulses++;
      tick();
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", pulses); end
    ref_div(63, 8, q, r, dz, elat);
    launch(63, 8);
    wait_done(lat, bc);
    checks++; if (lat != elat) begin errors++; $display("FAIL after_abort_latency: got %0d want %0d", lat, elat); end
    checks++; if (quotient !== 12'(q)) begin errors++; $display("FAIL after_abort_q: got %0d want %0d", quotient, q); end
    checks++; if (remainder !== 6'(r)) begin errors++; $display("FAIL after_abort_r: got %0d want %0d", remainder, r); end
    tick();
  endtask

  task automatic test_back_to_back();
    int a, b, na, nb, lat, bc;
    a = int'($urandom_range(0, 4095));
    b = int'($urandom_range(1, 63));
    launch(a, b);
    for (int n = 0; n < 200; n++) begin
      wait_done(lat, bc);
      checks++; if (lat != 12) begin errors++; $display("FAIL b2b%0d_latency: got %0d want 12", n, lat); end
      checks++; if (int'(quotient) * b + int'(remainder) != a) begin
        errors++; $display("FAIL b2b%0d_identity: got q=%0d r=%0d for %0d/%0d", n, quotient, remainder, a, b);
      end
      checks++; if (int'(remainder) >= b) begin errors++; $display("FAIL b2b%0d_rem_bound: got r=%0d want < %0d", n, remainder, b); end
      if (n < 199) begin
        na = int'($urandom_range(0, 4095));
        nb = int'($urandom_range(1, 63));
        launch(na, nb);              // taken on the edge that ends DONE
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin
          errors++; $display("FAIL b2b%0d_accept: got busy=%b done=%b want 1 0", n, busy, done);
        end
        a = na;
        b = nb;
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_div_zero();
    test_start_in_run();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider_12x6.md
SEQ_DIVIDER_12X6 -- requirements
Module: seq_divider_12x6

Interface
REQ-001 SHALL have parameter DIVIDEND_W, default 12, meaning dividend and quotient width.
REQ-002 SHALL have parameter DIVISOR_W, default 6, meaning divisor and remainder width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, meaning request to begin a division.
REQ-006 SHALL have port dividend, input, DIVIDEND_W, meaning unsigned numerator, sampled on accept.
REQ-007 SHALL have port divisor, input, DIVISOR_W, meaning unsigned denominator, sampled on accept.
REQ-008 SHALL have port busy, output, 1, meaning a division is in progress.
REQ-009 SHALL have port done, output, 1, meaning a one-cycle pulse that marks results valid.
REQ-010 SHALL have port quotient, output, DIVIDEND_W, meaning the result quotient.
REQ-011 SHALL have port remainder, output, DIVISOR_W, meaning the result remainder.
REQ-012 SHALL have port div_by_zero, output, 1, meaning the last result came from divisor==0.

Function
REQ-013 SHALL use an FSM with states IDLE, RUN and DONE.
REQ-014 SHALL accept a request when start=1 at a rising edge in IDLE or DONE, capture dividend and divisor, and enter RUN.
REQ-015 SHALL ignore start while in RUN; operands are not re-sampled and the result is unaffected.
REQ-016 SHALL perform one restoring shift-subtract step per RUN cycle, for exactly DIVIDEND_W cycles, using a DIVISOR_W+1-bit partial remainder.
REQ-017 SHALL, with an accept at edge k, drive busy=1 after edges k through k+DIVIDEND_W-1 and busy=0 after edge k+DIVIDEND_W.
REQ-018 SHALL enter DONE after edge k+DIVIDEND_W, pulse done=1 for exactly one cycle, and return to IDLE on the next edge unless a new start is accepted.
REQ-019 SHALL update quotient, remainder and div_by_zero only on entry to DONE, and hold them until the next DONE entry or reset.
REQ-020 SHALL produce results that satisfy quotient*divisor + remainder == dividend and remainder < divisor for every divisor != 0.
REQ-021 SHALL support back-to-back operation: a start during the DONE cycle is accepted on that edge with no idle gap.

Reset
REQ-022 SHALL, when rst=1 at a rising edge, force the FSM to IDLE and clear busy, done, quotient, remainder and div_by_zero to 0.
REQ-023 SHALL let reset win over a simultaneous start; an aborted division produces no done pulse.

Configuration
REQ-024 SHALL, when DIV_ZERO_CHECK_EN is defined, detect divisor==0 at accept and skip RUN.
- The FSM goes straight to DONE on the next edge: done after edge k+1, busy never asserted.
- Outputs: quotient = all ones, remainder = 0, div_by_zero = 1.
REQ-025 SHALL, when DIV_ZERO_CHECK_EN is undefined, process divisor==0 through the normal RUN sequence.
- Outputs: quotient = all ones, remainder = dividend[DIVISOR_W-1:0].
- div_by_zero is tied to 0.
- Latency is as in REQ-017.

Structure
REQ-026 SHALL take its state enum (IDLE/RUN/DONE) and default width constants from shared package div_pkg.
REQ-027 SHALL implement one restoring step (shift in dividend bit, trial subtract, select, quotient bit) in combinational sub-module div_step, instantiated once.

Verification
REQ-028 Bench SHALL drive 100/7 -> done after edge k+12, quotient=14, remainder=2, div_by_zero=0.
REQ-029 Bench SHALL drive 4095/63 -> quotient=65, remainder=0; then 0/5 -> quotient=0, remainder=0.
REQ-030 Bench SHALL drive 37/0.
- With DIV_ZERO_CHECK_EN: done after edge k+1, quotient=4095, remainder=0, div_by_zero=1.
- Without: done after edge k+12, quotient=4095, remainder=37, div_by_zero=0.
REQ-031 Bench SHALL accept 200/9, then pulse start with 50/3 at edge k+5 -> result is quotient=22, remainder=2, exactly one done pulse.
REQ-032 Bench SHALL accept 1000/10, assert rst at edge k+6 -> all outputs 0, no done pulse; then 63/8 -> quotient=7, remainder=7.
REQ-033 Bench SHALL run 200 random operand pairs with a nonzero divisor, each started in the DONE cycle of the previous one, and check REQ-020 plus the done timing for each.
